// File: rtl/chroma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chroma_pkg
//  Description : Shared types, mode encodings, default burst parameters and
//                the quadrature modulation helper for the chroma modulator.
//  Revision    : 1.0  initial release
// ============================================================================
package chroma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    localparam logic c_MODE_PAL  = 1'b0;
    localparam logic c_MODE_NTSC = 1'b1;

    localparam int c_BURST_START    = 10;
    localparam int c_BURST_LEN_PAL  = 40;
    localparam int c_BURST_LEN_NTSC = 36;
    localparam int c_BURST_AMP      = 40;
    localparam int c_BURST_AMP_PAL  = 28;

    // Quadrature phases 0..3 select +U, +V', -U, -V'; 9-bit width absorbs -(-128).
    function automatic logic signed [8:0] quad_mod(
        input logic [1:0]        ph,
        input logic signed [8:0] su,
        input logic signed [8:0] sv,
        input logic              flip_v
    );
        logic signed [8:0] svp;
        svp = flip_v ? -sv : sv;
        case (ph)
            2'd0:    return su;
            2'd1:    return svp;
            2'd2:    return -su;
            default: return -svp;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cc_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : cc_sync_edge
//  Description : Three-flop synchroniser with a one-cycle rising-edge pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module cc_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign rise = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/chroma_modulator.sv
`default_nettype none
// ============================================================================
//  Module      : chroma_modulator
//  Description : Quadrature U/V chroma modulator with colour-burst insertion
//                and PAL line-alternating V switch, clocked by the fast clock.
//  Revision    : 1.0  initial release
// ============================================================================
module chroma_modulator
    import chroma_pkg::*;
#(
    parameter int BURST_START    = c_BURST_START,
    parameter int BURST_LEN_PAL  = c_BURST_LEN_PAL,
    parameter int BURST_LEN_NTSC = c_BURST_LEN_NTSC,
    parameter int BURST_AMP      = c_BURST_AMP,
    parameter int BURST_AMP_PAL  = c_BURST_AMP_PAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clkcolor4x,
    input  logic              mode,
    input  logic              hsync,
    input  logic              blank,
    input  logic [7:0]        u,
    input  logic [7:0]        v,
    output logic signed [8:0] chroma,
    output logic              burst,
    output logic [1:0]        phase,
    output logic              pal_sw
);

    localparam logic [5:0]        c_START_LAST = 6'(BURST_START - 1);
    localparam logic [5:0]        c_PAL_LAST   = 6'(BURST_LEN_PAL - 1);
    localparam logic [5:0]        c_NTSC_LAST  = 6'(BURST_LEN_NTSC - 1);
    localparam logic signed [8:0] c_AMP_NTSC   = 9'(BURST_AMP);
    localparam logic signed [8:0] c_AMP_PAL    = 9'(BURST_AMP_PAL);

    logic              w_tick;
    logic              w_hs_rise;
    logic              w_hs_fall;
    logic [5:0]        w_len_last;
    logic signed [8:0] w_su_burst;
    logic signed [8:0] w_sv_burst;
    logic signed [8:0] w_su_pic;
    logic signed [8:0] w_sv_pic;
    logic signed [8:0] w_chroma_burst;
    logic signed [8:0] w_chroma_pic;

    logic              r_hsync_d;
    logic              r_mode_l;
    logic              r_pal_sw;
    logic              r_burst;
    logic [1:0]        r_phase;
    logic [5:0]        r_cnt;
    logic signed [8:0] r_chroma;
    state_t            r_state;

    cc_sync_edge u_color_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (clkcolor4x),
        .rise (w_tick)
    );

    assign w_hs_rise  = hsync & ~r_hsync_d;
    assign w_hs_fall  = ~hsync & r_hsync_d;
    assign w_len_last = (r_mode_l == c_MODE_NTSC) ? c_NTSC_LAST : c_PAL_LAST;

    // NTSC burst sits on -U; PAL burst is -U+V, the V switch swings it 135/225 deg.
    assign w_su_burst = (r_mode_l == c_MODE_NTSC) ? -c_AMP_NTSC : -c_AMP_PAL;
    assign w_sv_burst = (r_mode_l == c_MODE_NTSC) ? 9'sd0 : c_AMP_PAL;
    assign w_su_pic   = blank ? 9'sd0 : {u[7], u};
    assign w_sv_pic   = blank ? 9'sd0 : {v[7], v};

    assign w_chroma_burst = quad_mod(r_phase, w_su_burst, w_sv_burst, r_pal_sw);
    assign w_chroma_pic   = quad_mod(r_phase, w_su_pic, w_sv_pic, r_pal_sw);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync_d <= 1'b0;
            r_mode_l  <= c_MODE_PAL;
            r_pal_sw  <= 1'b0;
            r_burst   <= 1'b0;
            r_phase   <= 2'd0;
            r_cnt     <= 6'd0;
            r_chroma  <= 9'sd0;
            r_state   <= ST_IDLE;
        end else begin
            r_hsync_d <= hsync;
            if (w_tick) begin
                r_phase  <= r_phase + 2'd1;
                r_chroma <= r_burst ? w_chroma_burst : w_chroma_pic;
            end
            // Later assignments below override the default chroma source on
            // the edge where the burst flag itself changes.
            if (w_hs_rise) begin
                r_mode_l <= mode;
                r_pal_sw <= (mode == c_MODE_PAL) ? ~r_pal_sw : 1'b0;
                r_state  <= ST_IDLE;
                r_cnt    <= 6'd0;
                r_burst  <= 1'b0;
                if (w_tick) begin
                    r_chroma <= w_chroma_pic;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_hs_fall) begin
                            r_state <= ST_DELAY;
                            r_cnt   <= 6'd0;
                        end
                    end
                    ST_DELAY: begin
                        if (w_tick) begin
                            if (r_cnt == c_START_LAST) begin
                                r_state  <= ST_BURST;
                                r_cnt    <= 6'd0;
                                r_burst  <= 1'b1;
                                r_chroma <= w_chroma_burst;
                            end else begin
                                r_cnt <= r_cnt + 6'd1;
                            end
                        end
                    end
                    ST_BURST: begin
                        if (w_tick) begin
                            if (r_cnt == w_len_last) begin
                                r_state  <= ST_IDLE;
                                r_cnt    <= 6'd0;
                                r_burst  <= 1'b0;
                                r_chroma <= w_chroma_pic;
                            end else begin
                                r_cnt <= r_cnt + 6'd1;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign chroma = r_chroma;
    assign burst  = r_burst;
    assign phase  = r_phase;
    assign pal_sw = r_pal_sw;

endmodule
`default_nettype wire

// File: tb/tb_chroma_modulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chroma_modulator
//  Description : Directed scoreboard bench for chroma_modulator.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_chroma_modulator;

    typedef struct packed {
        logic [8:0] chroma;
        logic       burst;
        logic [1:0] phase;
        logic       pal_sw;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clkcolor4x = 1'b0;
    logic              mode = 1'b0;
    logic              hsync = 1'b0;
    logic              blank = 1'b0;
    logic [7:0]        u = 8'd0;
    logic [7:0]        v = 8'd0;
    logic signed [8:0] chroma;
    logic              burst;
    logic [1:0]        phase;
    logic              pal_sw;

    int   n_checks = 0;
    int   n_fails  = 0;
    exp_t sb[$];

    // Reference model state; m_since counts ticks since hsync fall, -1 = idle.
    int m_phase = 0, m_chroma = 0, m_burst = 0, m_pal_sw = 0, m_mode_l = 0, m_since = -1;
    int line_tick = 0, burst_ticks = 0, first_burst = -1;

    always #5 clk = ~clk;

    chroma_modulator dut (
        .clk        (clk),
        .rst        (rst),
        .clkcolor4x (clkcolor4x),
        .mode       (mode),
        .hsync      (hsync),
        .blank      (blank),
        .u          (u),
        .v          (v),
        .chroma     (chroma),
        .burst      (burst),
        .phase      (phase),
        .pal_sw     (pal_sw)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_chroma = 0; m_burst = 0; m_pal_sw = 0; m_mode_l = 0; m_since = -1;
    endtask

    task automatic model_hs_rise();
        m_mode_l = int'(mode);
        m_pal_sw = (mode == 1'b0) ? 1 - m_pal_sw : 0;
        m_since  = -1;
        m_burst  = 0;
    endtask

    task automatic model_tick();
        int len, su, sv, c;
        len = (m_mode_l == 1) ? 36 : 40;
        if (m_since >= 0) begin
            m_since++;
            m_burst = (m_since >= 10 && m_since < 10 + len) ? 1 : 0;
            if (m_since >= 10 + len) m_since = -1;
        end
        if (m_burst != 0) begin
            su = (m_mode_l == 1) ? -40 : -28;
            sv = (m_mode_l == 1) ? 0 : 28;
        end else if (blank) begin
            su = 0; sv = 0;
        end else begin
            su = int'($signed(u)); sv = int'($signed(v));
        end
        if (m_pal_sw != 0) sv = -sv;
        case (m_phase)
            0:       c = su;
            1:       c = sv;
            2:       c = -su;
            default: c = -sv;
        endcase
        m_chroma = c;
        m_phase  = (m_phase + 1) % 4;
    endtask

    // One subcarrier rising edge; outputs must move exactly two clocks after first sample.
    task automatic tick(input bit hs_at_tick = 1'b0, input bit hold_high = 1'b0);
        exp_t e;
        int pc, pp;
        pc = m_chroma; pp = m_phase;
        @(negedge clk) clkcolor4x = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pre_update_phase", phase, pp);
        check("pre_update_chroma", chroma, pc);
        if (hs_at_tick) begin
            hsync = 1'b1;
            model_hs_rise();
        end
        model_tick();
        e.chroma = m_chroma[8:0];
        e.burst  = m_burst[0];
        e.phase  = m_phase[1:0];
        e.pal_sw = m_pal_sw[0];
        sb.push_back(e);
        if (!hold_high) clkcolor4x = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        check("chroma", chroma, $signed(e.chroma));
        check("burst", burst, e.burst);
        check("phase", phase, e.phase);
        check("pal_sw", pal_sw, e.pal_sw);
        line_tick++;
        if (burst === 1'b1) begin
            if (burst_ticks == 0) first_burst = line_tick;
            burst_ticks++;
        end
    endtask

    task automatic start_count();
        line_tick = 0; burst_ticks = 0; first_burst = -1;
    endtask

    task automatic hsync_line();
        @(negedge clk) hsync = 1'b1;
        model_hs_rise();
        @(negedge clk);
        check("hs_rise_burst", burst, 0);
        check("hs_rise_pal_sw", pal_sw, m_pal_sw);
        repeat (3) @(negedge clk);
        hsync = 1'b0;
        if (m_since < 0) m_since = 0;
        @(negedge clk);
        start_count();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_chroma", chroma, 0);
        check("rst_burst", burst, 0);
        check("rst_phase", phase, 0);
        check("rst_pal_sw", pal_sw, 0);
        rst = 1'b0;

        // NTSC picture carrier: +50, 0, -50, 0
        mode = 1'b1; blank = 1'b0; u = 8'd50; v = 8'd0;
        repeat (8) tick();

        // Extreme values: -128, +127, +128, -127
        u = 8'h80; v = 8'h7f;
        repeat (4) tick();

        // NTSC burst timing on a blanked line
        blank = 1'b1;
        hsync_line();
        repeat (50) tick();
        check("ntsc_first_burst_tick", first_burst, 10);
        check("ntsc_burst_len", burst_ticks, 36);

        // PAL lines: V switch alternates, burst 40 ticks
        mode = 1'b0;
        for (int l = 0; l < 3; l++) begin
            hsync_line();
            check("pal_sw_line", pal_sw, (l % 2 == 0) ? 1 : 0);
            repeat (50) tick();
            check("pal_burst_len", burst_ticks, 40);
        end
        blank = 1'b0; u = 8'd0; v = 8'd20;
        repeat (2) begin
            hsync_line();
            repeat (4) tick();
        end

        // hsync rising at burst tick 15 coincides with a tick
        blank = 1'b1;
        hsync_line();
        repeat (24) tick();
        check("burst_mid", burst, 1);
        tick(1'b1);
        check("abort_burst", burst, 0);
        repeat (4) tick();
        @(negedge clk) hsync = 1'b0;
        m_since = 0;
        @(negedge clk);
        start_count();
        repeat (12) tick();
        check("restart_first_burst", first_burst, 10);

        // Generator disabled: clkcolor4x held high freezes everything
        tick(1'b0, 1'b1);
        repeat (100) @(negedge clk);
        check("frozen_phase", phase, m_phase);
        check("frozen_chroma", chroma, m_chroma);
        check("frozen_burst", burst, m_burst);
        clkcolor4x = 1'b0;
        repeat (2) @(negedge clk);

        // Mode change mid-line applies at next hsync
        mode = 1'b0;
        hsync_line();
        repeat (3) tick();
        mode = 1'b1;
        repeat (47) tick();
        check("midline_pal_len", burst_ticks, 40);
        hsync_line();
        check("ntsc_pal_sw", pal_sw, 0);
        repeat (50) tick();
        check("next_ntsc_len", burst_ticks, 36);

        // Asynchronous reset mid-burst
        hsync_line();
        repeat (20) tick();
        #2 rst = 1'b1;
        #1;
        check("async_rst_chroma", chroma, 0);
        check("async_rst_burst", burst, 0);
        check("async_rst_phase", phase, 0);
        check("async_rst_pal_sw", pal_sw, 0);
        model_reset();
        @(negedge clk) rst = 1'b0;
        start_count();
        repeat (12) tick();
        check("no_restart_without_fall", burst_ticks, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
